synth_note_sequencer: RTL and testbench

Plays a programmed note sequence on the `Synthesizer` block: holds a small step memory of (tone, cutoff, length) entries and walks it on sample ticks. For each step it drives the synthesizer's `frequencies`, `voice_volumes` and `cutoff` inputs. Frequencies are computed as a Q12.20 base frequency times a just-intonation ratio. The block sits between the host/OSD register interface and `Synthesizer`.

---
 rtl/synth_note_sequencer_if.sv | 32 +++
 rtl/synth_note_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_synth_note_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_note_sequencer_if.sv
// rtl/synth_note_sequencer_if.sv - host/synth-facing signal bundle for the note sequencer
interface synth_note_sequencer_if #(
    parameter int VOICES = 8,
    parameter int STEPS  = 16
);
    localparam int AW = $clog2(STEPS);

    logic                    sample_tick;
    logic                    start;
    logic                    stop;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [10:0]             wr_data;
    logic [VOICES-1:0][31:0] frequencies;
    logic [VOICES-1:0][31:0] voice_volumes;
    logic [2:0]              cutoff;
    logic                    busy;
    logic [AW-1:0]           step;
    logic                    done;

    // host side: drives control and step writes, observes synth drive
    modport master (
        output sample_tick, start, stop, wr_en, wr_addr, wr_data,
        input  frequencies, voice_volumes, cutoff, busy, step, done
    );

    // sequencer side
    modport slave (
        input  sample_tick, start, stop, wr_en, wr_addr, wr_data,
        output frequencies, voice_volumes, cutoff, busy, step, done
    );
endinterface

// File: rtl/synth_note_sequencer.sv
// rtl/synth_note_sequencer.sv - step-memory note sequencer driving the synthesizer (option: SEQ_LOOP_EN)
module synth_note_sequencer #(
    parameter int          VOICES      = 8,
    parameter int          STEPS       = 16,
    parameter int          SAMPLE_RATE = 48000,
    parameter int          BASE_FREQ   = 110,
    parameter logic [31:0] VOLUME      = 32'h0010_0000
) (
    input logic                   clk,
    input logic                   reset,
    synth_note_sequencer_if.slave seq_bus
);
    localparam int          AW        = $clog2(STEPS);
    localparam logic [31:0] QUARTER   = 32'(SAMPLE_RATE / 4);
    localparam logic [63:0] BASE_Q20  = 64'(BASE_FREQ) << 20;
    localparam logic [3:0]  TONE_END  = 4'd15;
    localparam logic [3:0]  TONE_REST = 4'd13;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_HOLD, S_FIN} state_t;

    // just-intonation ratios in Q20, floor of 2^20 * ratio
    function automatic logic [31:0] ratio_q20(input logic [3:0] tone);
        case (tone)
            4'd0:    ratio_q20 = 32'd1048576;
            4'd1:    ratio_q20 = 32'd1118481;
            4'd2:    ratio_q20 = 32'd1179648;
            4'd3:    ratio_q20 = 32'd1258291;
            4'd4:    ratio_q20 = 32'd1310720;
            4'd5:    ratio_q20 = 32'd1398101;
            4'd6:    ratio_q20 = 32'd1474560;
            4'd7:    ratio_q20 = 32'd1572864;
            4'd8:    ratio_q20 = 32'd1677721;
            4'd9:    ratio_q20 = 32'd1747626;
            4'd10:   ratio_q20 = 32'd1864135;
            4'd11:   ratio_q20 = 32'd1966080;
            4'd12:   ratio_q20 = 32'd2097152;
            default: ratio_q20 = 32'd1048576;
        endcase
    endfunction

    logic [10:0]             r_mem [STEPS];
    state_t                  r_state;
    logic [10:0]             r_entry;
    logic [AW-1:0]           r_step;
    logic [31:0]             r_hold_cnt;
    logic [VOICES-1:0][31:0] r_freq;
    logic [VOICES-1:0][31:0] r_vol;
    logic [2:0]              r_cutoff;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [AW-1:0]           w_step_nxt;
    logic [31:0]             w_hold_nxt;
    logic [VOICES-1:0][31:0] w_freq_nxt;
    logic [VOICES-1:0][31:0] w_vol_nxt;
    logic [2:0]              w_cutoff_nxt;
    logic                    w_done_nxt;

    logic [3:0]  w_tone;
    logic [2:0]  w_cut;
    logic [3:0]  w_len;
    logic [31:0] w_target;
    logic [31:0] w_note;
    logic        w_hold_hit;
    logic        w_end_mark;
    logic        w_advance;
    logic        w_last;
    logic        w_seq_end;

    assign w_tone     = r_entry[10:7];
    assign w_cut      = r_entry[6:4];
    assign w_len      = r_entry[3:0];
    assign w_target   = 32'(w_len) * QUARTER;
    assign w_note     = 32'((BASE_Q20 * {32'd0, ratio_q20(w_tone)}) >> 20);
    assign w_hold_hit = (r_hold_cnt + 32'd1) == w_target;
    assign w_end_mark = (r_state == S_CALC) && (w_tone == TONE_END);
    // a step finishes either straight out of CALC (zero length) or on its final counted tick
    assign w_advance  = ((r_state == S_CALC) && (w_tone != TONE_END) && (w_len == 4'd0)) ||
                        ((r_state == S_HOLD) && seq_bus.sample_tick && w_hold_hit);
    assign w_last     = r_step == AW'(STEPS - 1);
    assign w_seq_end  = w_end_mark || (w_advance && w_last);

    assign seq_bus.frequencies   = r_freq;
    assign seq_bus.voice_volumes = r_vol;
    assign seq_bus.cutoff        = r_cutoff;
    assign seq_bus.busy          = r_state != S_IDLE;
    assign seq_bus.step          = r_step;
    assign seq_bus.done          = r_done;

    // step memory: writable in any state, never reset
    always_ff @(posedge clk) begin
        if (seq_bus.wr_en) begin
            r_mem[seq_bus.wr_addr] <= seq_bus.wr_data;
        end
    end

    // state and datapath registers; LOAD reads the old entry on a same-address write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_entry    <= '0;
            r_step     <= '0;
            r_hold_cnt <= '0;
            r_freq     <= '0;
            r_vol      <= '0;
            r_cutoff   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_freq     <= w_freq_nxt;
            r_vol      <= w_vol_nxt;
            r_cutoff   <= w_cutoff_nxt;
            r_done     <= w_done_nxt;
            if (r_state == S_LOAD) begin
                r_entry <= r_mem[r_step];
            end
        end
    end

    // next state: stop overrides everything, sequence end/advance override the per-state choice
    always_comb begin
        w_state_nxt = r_state;
        if (seq_bus.stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (seq_bus.start) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = S_CALC;
                S_CALC:  if (w_len != 4'd0) w_state_nxt = S_HOLD;
                S_HOLD:  w_state_nxt = S_HOLD;
                S_FIN:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_seq_end) begin
`ifdef SEQ_LOOP_EN
                w_state_nxt = S_LOAD;
`else
                w_state_nxt = S_FIN;
`endif
            end else if (w_advance) begin
                w_state_nxt = S_LOAD;
            end
        end
    end

    // output/datapath next values: note calc in CALC, tick counting in HOLD, silence on stop/FIN
    always_comb begin
        w_step_nxt   = r_step;
        w_hold_nxt   = r_hold_cnt;
        w_freq_nxt   = r_freq;
        w_vol_nxt    = r_vol;
        w_cutoff_nxt = r_cutoff;
        w_done_nxt   = 1'b0;
        if (seq_bus.stop) begin
            w_vol_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seq_bus.start) w_step_nxt = '0;
                end
                S_CALC: begin
                    if (!w_end_mark) begin
                        w_cutoff_nxt = w_cut;
                        w_hold_nxt   = '0;
                        if (w_tone >= TONE_REST) begin
                            w_vol_nxt = '0;
                        end else begin
                            for (int i = 0; i < VOICES; i++) begin
                                w_freq_nxt[i] = w_note << (i % 3);
                                w_vol_nxt[i]  = VOLUME;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (seq_bus.sample_tick) w_hold_nxt = r_hold_cnt + 32'd1;
                end
                S_FIN: begin
                    w_vol_nxt = '0;
                end
                default: begin
                end
            endcase
            if (w_seq_end) begin
                w_done_nxt = 1'b1;
`ifdef SEQ_LOOP_EN
                w_step_nxt = '0;
`endif
            end else if (w_advance) begin
                w_step_nxt = r_step + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_synth_note_sequencer.sv
// tb/tb_synth_note_sequencer.sv - directed self-checking bench for synth_note_sequencer
module tb_synth_note_sequencer;
    localparam logic [31:0] VOL = 32'd1048576;
    localparam logic [31:0] F7  = 32'd173015040;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    synth_note_sequencer_if #(.VOICES(8), .STEPS(16)) bus ();

    synth_note_sequencer #(
        .VOICES(8), .STEPS(16), .SAMPLE_RATE(16), .BASE_FREQ(110), .VOLUME(32'h0010_0000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .seq_bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.sample_tick = 1'b1;
        cyc();
        bus.sample_tick = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic wr(input int a, input int tone, input int cut, input int len);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = {4'(tone), 3'(cut), 4'(len)};
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic halt();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        cyc();
    endtask

    function automatic int end_step(input int last);
`ifdef SEQ_LOOP_EN
        end_step = 0;
`else
        end_step = last;
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int early;
        bus.sample_tick = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        reset           = 1'b1;
        cyc();
        cyc();
        chk("rst_freq0", bus.frequencies[0], 0);
        chk("rst_vol0", bus.voice_volumes[0], 0);
        chk("rst_cutoff", bus.cutoff, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_step", bus.step, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b0;
        cyc();

        // single note, then end marker
        wr(0, 7, 1, 1);
        wr(1, 15, 0, 0);
        pulse_start();
        chk("a_busy_t1", bus.busy, 1);
        chk("a_step_t1", bus.step, 0);
        cyc();
        cyc();
        chk("a_freq0", bus.frequencies[0], F7);
        chk("a_freq1", bus.frequencies[1], 32'd346030080);
        chk("a_freq2", bus.frequencies[2], 32'd692060160);
        chk("a_freq3", bus.frequencies[3], F7);
        chk("a_vol0", bus.voice_volumes[0], VOL);
        chk("a_vol7", bus.voice_volumes[7], VOL);
        chk("a_cutoff", bus.cutoff, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("a_done", bus.done, (k == 4) ? 1 : 0);
        end
        chk("a_step_done", bus.step, end_step(1));
`ifndef SEQ_LOOP_EN
        cyc();
        chk("a_busy_after", bus.busy, 0);
        chk("a_vol_after", bus.voice_volumes[0], 0);
        chk("a_done_after", bus.done, 0);
`endif
        halt();

        // ratio truncation with zero-length steps
        wr(0, 1, 2, 0);
        wr(1, 12, 3, 0);
        wr(2, 15, 0, 0);
        pulse_start();
        cyc();
        cyc();
        chk("b_tone1", bus.frequencies[0], 32'd123032910);
        chk("b_cut2", bus.cutoff, 2);
        chk("b_step1", bus.step, 1);
        cyc();
        cyc();
        chk("b_tone12_f0", bus.frequencies[0], 32'd230686720);
        chk("b_tone12_f1", bus.frequencies[1], 32'd461373440);
        chk("b_tone12_f2", bus.frequencies[2], 32'd922746880);
        chk("b_cut3", bus.cutoff, 3);
        chk("b_step2", bus.step, 2);
        cyc();
        cyc();
        chk("b_done", bus.done, 1);
        halt();

        // rest step with length 2 (8 ticks)
        wr(0, 7, 1, 1);
        wr(1, 13, 5, 2);
        wr(2, 15, 0, 0);
        pulse_start();
        cyc();
        cyc();
        chk("c_note", bus.frequencies[0], F7);
        for (int k = 0; k < 4; k++) tick();
        chk("c_rest_vol0", bus.voice_volumes[0], 0);
        chk("c_rest_vol5", bus.voice_volumes[5], 0);
        chk("c_rest_cut", bus.cutoff, 5);
        chk("c_rest_freq", bus.frequencies[0], F7);
        chk("c_rest_step", bus.step, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("c_done", bus.done, (k == 8) ? 1 : 0);
        end
        halt();

        // start and stop together
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("e_ss_busy", bus.busy, 0);
        cyc();
        chk("e_ss_busy2", bus.busy, 0);

        // stop mid-hold
        wr(0, 7, 1, 1);
        wr(1, 15, 0, 0);
        pulse_start();
        cyc();
        cyc();
        tick();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("e_stop_busy", bus.busy, 0);
        chk("e_stop_vol", bus.voice_volumes[0], 0);
        chk("e_stop_done", bus.done, 0);
        cyc();
        chk("e_stop_done2", bus.done, 0);

        // start while busy is ignored: hold count keeps running
        pulse_start();
        cyc();
        cyc();
        tick();
        pulse_start();
        chk("e_rs_step", bus.step, 0);
        chk("e_rs_busy", bus.busy, 1);
        for (int k = 0; k < 3; k++) tick();
        chk("e_rs_done", bus.done, 1);
        halt();

        // reset mid-hold, then replay from surviving memory
        pulse_start();
        cyc();
        cyc();
        tick();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("e_rst_freq", bus.frequencies[0], 0);
        chk("e_rst_vol", bus.voice_volumes[0], 0);
        chk("e_rst_cut", bus.cutoff, 0);
        chk("e_rst_busy", bus.busy, 0);
        chk("e_rst_step", bus.step, 0);
        chk("e_rst_done", bus.done, 0);
        pulse_start();
        cyc();
        cyc();
        chk("e_rp_freq2", bus.frequencies[2], 32'd692060160);
        chk("e_rp_vol", bus.voice_volumes[3], VOL);
        chk("e_rp_cut", bus.cutoff, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("e_rp_done", bus.done, 1);
        halt();

        // write collision during LOAD of step 1
        wr(0, 7, 1, 0);
        wr(1, 1, 2, 1);
        wr(2, 15, 0, 0);
        pulse_start();
        cyc();
        cyc();
        chk("f_load_step", bus.step, 1);
        wr(1, 12, 6, 0);
        cyc();
        chk("f_old_freq", bus.frequencies[0], 32'd123032910);
        chk("f_old_cut", bus.cutoff, 2);
        for (int k = 0; k < 4; k++) tick();
        chk("f_done", bus.done, 1);
        halt();
        pulse_start();
        cyc();
        cyc();
        cyc();
        cyc();
        chk("f_new_freq", bus.frequencies[0], 32'd230686720);
        chk("f_new_cut", bus.cutoff, 6);
        halt();

        // full memory, no end marker, all zero length
        for (int i = 0; i < 16; i++) wr(i, i % 13, i % 8, 0);
        pulse_start();
        early = 0;
        for (int n = 2; n <= 32; n++) begin
            cyc();
            if (bus.done) early++;
        end
        chk("g_early_done", early, 0);
        cyc();
        chk("g_done", bus.done, 1);
        chk("g_step", bus.step, end_step(15));
        chk("g_busy", bus.busy, 1);
        chk("g_freq15", bus.frequencies[0], 32'd129761280);
        chk("g_cut15", bus.cutoff, 7);
        cyc();
`ifdef SEQ_LOOP_EN
        chk("g_busy_after", bus.busy, 1);
`else
        chk("g_busy_after", bus.busy, 0);
        chk("g_step_after", bus.step, 15);
`endif
        halt();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
